// File: rtl/tinyqv_fetch_aligner_pkg.sv
// Shared constants for the fetch aligner and the decoder that consumes its
// output: instruction length encodings and the RVC "uncompressed" opcode
// field value, plus a helper to classify a halfword.
package tinyqv_fetch_aligner_pkg;

    localparam logic [1:0] INSTR_LEN_16     = 2'b01;
    localparam logic [1:0] INSTR_LEN_32     = 2'b10;
    localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

    // Only bits [1:0] matter; [4:2]=3'b111 long encodings are left for the
    // decoder to reject and are treated as ordinary 32-bit here.
    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != OPC_UNCOMPRESSED;
    endfunction

endpackage

// File: rtl/tinyqv_fetch_aligner_hw_fifo.sv
// Halfword ring buffer, DEPTH x 16.
// One push port, head and head+1 read taps, pop of 0/1/2 entries per cycle.
// Ports:
//   clk, rstn    clock, async active-low reset
//   flush        empties the buffer (pointers and count to 0); wins over push/pop
//   push         write push_data at the write pointer
//   push_data    halfword to store
//   pop_n        entries to remove this cycle (0..2)
//   head0/head1  entries at rd_ptr and rd_ptr+1 (modulo DEPTH)
//   count        occupied entries, 0..DEPTH
module tinyqv_fetch_aligner_hw_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       push,
    input  logic [15:0]                push_data,
    input  logic [1:0]                 pop_n,
    output logic [15:0]                head0,
    output logic [15:0]                head1,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][15:0] mem_q, mem_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          rd_ptr_p1;

    // Pointers are exactly log2(DEPTH) bits, so +1/+2 wraps on its own and a
    // 32-bit instruction can straddle the end of the array.
    assign rd_ptr_p1 = rd_ptr_q + AW'(1);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            rd_ptr_d = rd_ptr_q + AW'(pop_n);
            count_d  = count_q + CW'(push) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_ptr_p1];
    assign count = count_q;

endmodule

// File: rtl/tinyqv_fetch_aligner.sv
// Fetch aligner: turns the sequential halfword stream from the QSPI fetch
// path into whole 16/32-bit instructions, each tagged with its halfword PC
// and length, at any halfword alignment. A flush discards everything
// buffered and restarts at flush_pc.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   flush, flush_pc            redirect (priority over push/pop)
//   data_in/valid/ready        halfword input handshake
//   instr/instr_pc/instr_len   instruction to decoder (len 01=16b, 10=32b)
//   instr_valid/instr_ready    instruction output handshake
// All outputs come from registered state only, so there is no combinational
// path from data_valid or instr_ready to any output.
module tinyqv_fetch_aligner
    import tinyqv_fetch_aligner_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_BITS = 23
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic [PC_BITS-1:0] flush_pc,
    input  logic [15:0]        data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic [31:0]        instr,
    output logic [PC_BITS-1:0] instr_pc,
    output logic [1:0]         instr_len,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]        head0, head1;
    logic [CW-1:0]      count;
    logic               head_is_c;
    logic               push, pop;
    logic [1:0]         pop_n;
    logic [PC_BITS-1:0] pc_q, pc_d;

    tinyqv_fetch_aligner_hw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .push      (push),
        .push_data (data_in),
        .pop_n     (pop_n),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    assign head_is_c = is_compressed(head0);

    // A 32-bit head with only one halfword buffered stays invalid until its
    // upper half lands; partial instructions are never shown.
    assign instr_valid = ((count != '0) && head_is_c) || (count >= CW'(2));
    assign instr_len   = head_is_c ? INSTR_LEN_16 : INSTR_LEN_32;
    assign instr       = !instr_valid ? 32'h0 :
                         head_is_c    ? {16'h0, head0} : {head1, head0};
    assign instr_pc    = pc_q;

    // Full is judged on the registered count; a same-cycle pop does not
    // open a slot until the next cycle.
    assign data_ready = count < CW'(DEPTH);

    assign push  = data_valid && data_ready && !flush;
    assign pop   = instr_valid && instr_ready && !flush;
    assign pop_n = !pop ? 2'd0 : (head_is_c ? 2'd1 : 2'd2);

    always_comb begin
        pc_d = pc_q;
        if (flush)    pc_d = flush_pc;
        else if (pop) pc_d = pc_q + PC_BITS'(pop_n);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= '0;
        else       pc_q <= pc_d;
    end

endmodule
